// File: rtl/can_pkg.sv
// Shared types and defaults for the CAN bit stuffer.
// No logic; constants only.
// Not applicable (no handshake).
package can_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DYN   = 2'd1,
    S_FIXED = 2'd2
  } stuff_state_t;

  localparam int CAN_RUN_LEN_DEFAULT   = 5;
  localparam int CAN_FD_FIXED_INTERVAL = 4;

endpackage

// File: rtl/can_run_counter.sv
// 4-bit event counter with clear, increment and terminal-count compare.
// Count updates on the clock edge; tc is combinational from the count.
// No backpressure; clr together with inc restarts the count at 1.
module can_run_counter #(
  parameter logic [3:0] TC = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       tc
);

  // Counter register: clear wins, clear+inc starts a new run at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= {3'b000, inc};
    end else if (inc) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign tc = (cnt == TC);

endmodule

// File: rtl/can_bit_stuffer_p.sv
// CAN transmit bit stuffer: inserts dynamic (and, with CAN_STUFF_FD_FIXED_EN, fixed FD) stuff bits.
// One cycle from in_bit to bit_out; stuff bits take an output slot without consuming input.
// in_ready drops while the output slot is held (no tick) or a stuff bit is pending.
module can_bit_stuffer_p
  import can_pkg::*;
#(
  parameter int RUN_LEN        = CAN_RUN_LEN_DEFAULT,
  parameter int FIXED_INTERVAL = CAN_FD_FIXED_INTERVAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       stuff_en,
  input  logic       fixed_mode,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       bit_is_stuff,
  output logic [2:0] stuff_count
);

  // Run counter hits this value when the next equal bit completes a run.
  localparam logic [3:0] RUN_TC = 4'(RUN_LEN - 1);

  stuff_state_t state, state_nxt;
  logic         last_bit;
  logic         dyn_pend;
  logic         fix_pend;
  logic         slot_free, pend, load_stuff, load_data;
  logic         run_clr, run_inc, run_tc, run_cont;
  logic [3:0]   run_cnt;

  // State register; mode is re-derived from the inputs every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and load decisions; the new mode governs bits loaded at this edge.
  always_comb begin
    state_nxt = stuff_en ? S_DYN : S_IDLE;
`ifdef CAN_STUFF_FD_FIXED_EN
    if (fixed_mode) state_nxt = S_FIXED;
`endif
    slot_free  = !bit_valid || tick;
    pend       = dyn_pend || fix_pend;
    in_ready   = slot_free && !pend;
    load_stuff = slot_free && pend;
    load_data  = slot_free && !pend && in_valid;
    run_cont   = (run_cnt != 4'd0) && (in_bit == last_bit);
    run_inc    = (state_nxt == S_DYN) && (load_stuff || load_data);
    run_clr    = (state_nxt != S_DYN) || load_stuff || (load_data && !run_cont);
  end

  can_run_counter #(.TC(RUN_TC)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_clr),
    .inc   (run_inc),
    .cnt   (run_cnt),
    .tc    (run_tc)
  );

  // Dynamic stuff request survives a falling stuff_en until it is emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dyn_pend <= 1'b0;
    end else if (load_stuff && dyn_pend) begin
      dyn_pend <= 1'b0;
    end else if (load_data && (state_nxt == S_DYN) && run_cont && run_tc) begin
      dyn_pend <= 1'b1;
    end
  end

`ifdef CAN_STUFF_FD_FIXED_EN
  localparam logic [3:0] IVAL_TC = 4'(FIXED_INTERVAL - 1);

  logic       fix_pend_q, fix_entry, ival_tc;
  logic [3:0] ival_cnt;

  // Entering fixed mode requests a stuff bit ahead of the next data bit.
  assign fix_entry = (state_nxt == S_FIXED) && (state != S_FIXED);
  assign fix_pend  = fix_pend_q || fix_entry;

  can_run_counter #(.TC(IVAL_TC)) u_ival_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_nxt != S_FIXED) || (load_data && ival_tc)),
    .inc   ((state_nxt == S_FIXED) && load_data && !ival_tc),
    .cnt   (ival_cnt),
    .tc    (ival_tc)
  );

  // Fixed stuff request: on entry and after every interval of data bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fix_pend_q <= 1'b0;
    end else if (state_nxt != S_FIXED) begin
      fix_pend_q <= 1'b0;
    end else if (load_stuff && !dyn_pend) begin
      fix_pend_q <= 1'b0;
    end else if (fix_entry || (load_data && ival_tc)) begin
      fix_pend_q <= 1'b1;
    end
  end
`else
  logic unused_fixed_cfg;

  // Classic CAN only: fixed_mode is accepted on the port but has no effect.
  assign fix_pend         = 1'b0;
  assign unused_fixed_cfg = fixed_mode & (FIXED_INTERVAL > 0);
`endif

  // Output slot: stuff bit first, then data, else the slot empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      bit_is_stuff <= 1'b0;
      last_bit     <= 1'b1;
    end else if (load_stuff) begin
      bit_out      <= ~last_bit;
      bit_valid    <= 1'b1;
      bit_is_stuff <= 1'b1;
      last_bit     <= ~last_bit;
    end else if (load_data) begin
      bit_out      <= in_bit;
      bit_valid    <= 1'b1;
      bit_is_stuff <= 1'b0;
      last_bit     <= in_bit;
    end else if (slot_free) begin
      bit_valid    <= 1'b0;
      bit_is_stuff <= 1'b0;
    end
  end

  // Dynamic stuff counter: cleared when a stuffed frame section starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stuff_count <= 3'd0;
    end else if ((state == S_IDLE) && (state_nxt == S_DYN)) begin
      stuff_count <= 3'd0;
    end else if (load_stuff && dyn_pend) begin
      stuff_count <= stuff_count + 3'd1;
    end
  end

endmodule

// File: tb/tb_can_bit_stuffer_p.sv
// Self-checking bench for can_bit_stuffer_p: table vectors plus multi-cycle corner sequences.
// Expected serializer bits are queued when stimulus is queued and popped on each consuming tick.
// Ticks arrive every fourth cycle so the stuffer sees regular backpressure.
module tb_can_bit_stuffer_p;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       stuff_en = 1'b0;
  logic       fixed_mode = 1'b0;
  logic       in_bit0 = 1'b0, in_valid0 = 1'b0, in_ready0;
  logic       bit_out0, bit_valid0, bit_is_stuff0;
  logic [2:0] stuff_count0;
  logic       in_bit1 = 1'b0, in_valid1 = 1'b0, in_ready1;
  logic       bit_out1, bit_valid1, bit_is_stuff1;
  logic [2:0] stuff_count1;

  always #5 clk = ~clk;

  can_bit_stuffer_p dut0 (
    .clk(clk), .reset(reset), .tick(tick), .in_bit(in_bit0), .in_valid(in_valid0),
    .in_ready(in_ready0), .stuff_en(stuff_en), .fixed_mode(fixed_mode), .bit_out(bit_out0),
    .bit_valid(bit_valid0), .bit_is_stuff(bit_is_stuff0), .stuff_count(stuff_count0)
  );

  can_bit_stuffer_p #(.RUN_LEN(3)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .in_bit(in_bit1), .in_valid(in_valid1),
    .in_ready(in_ready1), .stuff_en(stuff_en), .fixed_mode(fixed_mode), .bit_out(bit_out1),
    .bit_valid(bit_valid1), .bit_is_stuff(bit_is_stuff1), .stuff_count(stuff_count1)
  );

  typedef struct {
    logic        sen;
    int          n_in;
    logic [15:0] din;
    int          n_out;
    logic [15:0] dout;
    logic [15:0] dstf;
    logic [2:0]  cnt;
  } vec_t;

  vec_t       vecs[7];
  logic       src0[$], src1[$];
  logic [1:0] exp0[$], exp1[$];
  int         checks = 0, failures = 0;
  int         tick_phase = 0, loads0 = 0;
  bit         mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer side: every tick that finds a valid bit pops one expectation.
  always @(negedge clk) begin
    if (!reset && mon_en && tick) begin
      if (bit_valid0) begin
        if (exp0.size() == 0) chk("dut0_unexpected_bit", 1, 0);
        else chk("dut0_bit", int'({bit_out0, bit_is_stuff0}), int'(exp0.pop_front()));
      end
      if (bit_valid1) begin
        if (exp1.size() == 0) chk("dut1_unexpected_bit", 1, 0);
        else chk("dut1_bit", int'({bit_out1, bit_is_stuff1}), int'(exp1.pop_front()));
      end
    end
  end

  task automatic step();
    logic r0, r1;
    tick       = (tick_phase == 3);
    tick_phase = (tick_phase + 1) % 4;
    in_valid0  = (src0.size() > 0);
    in_bit0    = in_valid0 ? src0[0] : 1'b0;
    in_valid1  = (src1.size() > 0);
    in_bit1    = in_valid1 ? src1[0] : 1'b0;
    @(negedge clk);
    r0 = in_ready0;
    r1 = in_ready1;
    @(posedge clk);
    if (in_valid0 && r0) begin void'(src0.pop_front()); loads0++; end
    if (in_valid1 && r1) void'(src1.pop_front());
    #1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 600 && (src0.size() + exp0.size() + src1.size() + exp1.size()) > 0; c++)
      step();
    chk(name, src0.size() + exp0.size() + src1.size() + exp1.size(), 0);
    tick = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    stuff_en = 1'b0; fixed_mode = 1'b0;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    loads0 = 0; tick_phase = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic push_data(input logic b, input int copies);
    for (int i = 0; i < copies; i++) begin
      src0.push_back(b);
      exp0.push_back({b, 1'b0});
    end
  endtask

  initial begin
    int stray;
    // {stuff_en, n_in, inputs, n_out, outputs, stuff flags, stuff_count}; bit i = item i.
    vecs[0] = '{1'b1, 6,  16'h003F, 7,  16'h005F, 16'h0020, 3'd1};
    vecs[1] = '{1'b1, 9,  16'h01E0, 11, 16'h03E0, 16'h0420, 3'd2};
    vecs[2] = '{1'b1, 6,  16'h0015, 6,  16'h0015, 16'h0000, 3'd0};
    vecs[3] = '{1'b0, 7,  16'h007F, 7,  16'h007F, 16'h0000, 3'd0};
    vecs[4] = '{1'b1, 9,  16'h01F0, 10, 16'h01F0, 16'h0200, 3'd1};
    vecs[5] = '{1'b1, 5,  16'h000F, 5,  16'h000F, 16'h0000, 3'd0};
    vecs[6] = '{1'b1, 10, 16'h0000, 12, 16'h0820, 16'h0820, 3'd2};

    // Reset values, checked while reset is held.
    #12;
    chk("rst_bit_out", int'(bit_out0), 0);
    chk("rst_bit_valid", int'(bit_valid0), 0);
    chk("rst_bit_is_stuff", int'(bit_is_stuff0), 0);
    chk("rst_stuff_count", int'(stuff_count0), 0);
    do_reset();
    chk("rst_in_ready", int'(in_ready0), 1);

    // One-cycle latency into an empty slot; slot then blocks without a tick.
    in_valid0 = 1'b1; in_bit0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    chk("lat_bit_valid", int'(bit_valid0), 1);
    chk("lat_bit_out", int'(bit_out0), 1);
    chk("lat_in_ready_held", int'(in_ready0), 0);

    // Table-driven frames on the default RUN_LEN instance.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      stuff_en = vecs[v].sen;
      for (int i = 0; i < vecs[v].n_in; i++) src0.push_back(vecs[v].din[i]);
      for (int i = 0; i < vecs[v].n_out; i++) exp0.push_back({vecs[v].dout[i], vecs[v].dstf[i]});
      drain($sformatf("vec%0d_drain", v));
      chk($sformatf("vec%0d_stuff_count", v), int'(stuff_count0), int'(vecs[v].cnt));
    end

    // Stuff counter wraps: 45 zeros give nine stuff bits, 9 mod 8 = 1.
    do_reset();
    stuff_en = 1'b1;
    for (int g = 0; g < 9; g++) begin
      push_data(1'b0, 5);
      exp0.push_back(2'b11);
    end
    drain("wrap_drain");
    chk("wrap_stuff_count", int'(stuff_count0), 1);

    // RUN_LEN=3 instance: 0,0,0,0 -> 0,0,0,stuff 1,0.
    do_reset();
    stuff_en = 1'b1;
    for (int i = 0; i < 4; i++) src1.push_back(1'b0);
    exp1.push_back(2'b00); exp1.push_back(2'b00); exp1.push_back(2'b00);
    exp1.push_back(2'b11); exp1.push_back(2'b00);
    drain("runlen3_drain");
    chk("runlen3_stuff_count", int'(stuff_count1), 1);

    // stuff_en falls right after the fifth 1 loads: trailing stuff still emitted.
    do_reset();
    stuff_en = 1'b1;
    push_data(1'b1, 5);
    exp0.push_back(2'b01);
    push_data(1'b1, 6);
    for (int c = 0; c < 100 && loads0 < 5; c++) step();
    chk("trail_fifth_loaded", loads0, 5);
    stuff_en = 1'b0;
    chk("trail_in_ready_pending", int'(in_ready0), 0);
    drain("trail_drain");

    // Reset with a stuff bit pending: outputs clear at once, nothing emitted after.
    do_reset();
    stuff_en = 1'b1;
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) src0.push_back(1'b1);
    for (int c = 0; c < 100 && loads0 < 5; c++) step();
    chk("rstpend_fifth_loaded", loads0, 5);
    #2 reset = 1'b1;
    #1;
    chk("rstpend_bit_out", int'(bit_out0), 0);
    chk("rstpend_bit_valid", int'(bit_valid0), 0);
    chk("rstpend_bit_is_stuff", int'(bit_is_stuff0), 0);
    @(negedge clk) reset = 1'b0;
    stuff_en = 1'b0;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bit_valid0) stray++;
    end
    chk("rstpend_no_stuff_after", stray, 0);
    chk("rstpend_in_ready", int'(in_ready0), 1);
    mon_en = 1'b1;
    tick = 1'b0;

    // Fixed-mode sequence after a dynamic frame (count 1) and a trailing 0.
    do_reset();
    stuff_en = 1'b1;
    push_data(1'b1, 5); exp0.push_back(2'b01); push_data(1'b1, 1);
    drain("fix_pre_dyn_drain");
    stuff_en = 1'b0;
    push_data(1'b0, 1);
    drain("fix_pre_zero_drain");
    fixed_mode = 1'b1;
`ifdef CAN_STUFF_FD_FIXED_EN
    for (int k = 0; k < 2; k++) begin
      exp0.push_back(2'b11);
      for (int i = 0; i < 4; i++) begin
        src0.push_back(i % 2 == 0);
        exp0.push_back({(i % 2 == 0) ? 1'b1 : 1'b0, 1'b0});
      end
    end
    exp0.push_back(2'b11);
`else
    for (int i = 0; i < 8; i++) begin
      src0.push_back(i % 2 == 0);
      exp0.push_back({(i % 2 == 0) ? 1'b1 : 1'b0, 1'b0});
    end
`endif
    drain("fix_drain");
    chk("fix_stuff_count_held", int'(stuff_count0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/can_bit_stuffer_p.md
CAN_BIT_STUFFER_P -- requirements
Module: can_bit_stuffer_p

Interface
REQ-001 RUN_LEN, 5: equal-polarity run length that triggers a dynamic stuff bit (legal 2..15).
REQ-002 FIXED_INTERVAL, 4: data bits between fixed stuff bits in fixed mode (legal 1..15).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle bit-time strobe; the serializer consumes bit_out on a tick.
REQ-006 in_bit  input  1  unstuffed bit from the MAC.
REQ-007 in_valid  input  1  in_bit valid.
REQ-008 in_ready  output  1  in_bit is loaded at this edge if in_valid=1.
REQ-009 stuff_en  input  1  dynamic stuffing window (SOF..CRC).
REQ-010 fixed_mode  input  1  CAN FD fixed-stuff window (stuff count + CRC).
REQ-011 bit_out  output  1  current bit to the serializer.
REQ-012 bit_valid  output  1  bit_out holds a bit.
REQ-013 bit_is_stuff  output  1  bit_out is an inserted stuff bit.
REQ-014 stuff_count  output  3  dynamic stuff bits inserted, modulo 8.

Function
REQ-015 The output register (bit_out, bit_valid, bit_is_stuff) loads only when the slot is free; the slot is free when bit_valid=0 or tick=1.
REQ-016 Load priority on a free slot: pending stuff bit first, then in_bit if in_valid=1; otherwise bit_valid<=0.
REQ-017 in_ready = slot free AND no stuff pending; it is combinational and independent of in_valid. Latency from in_bit to bit_out is one cycle.
REQ-018 Stuff bit value is the complement of the last loaded bit; a stuff bit never consumes input.
REQ-019 FSM states: S_IDLE (stuff_en=0, fixed_mode=0), S_DYN (stuff_en=1, fixed_mode=0), S_FIXED (fixed_mode=1, overrides stuff_en). The FSM is re-evaluated every cycle.
REQ-020 S_DYN run counting:
- run_cnt counts consecutive equal loaded bits, stuff bits included; a stuff bit starts a new run at 1.
- run_cnt==RUN_LEN sets stuff pending.
REQ-021 S_IDLE: run_cnt held at 0 and no stuffing. The first bit loaded after entering S_DYN starts its run at 1.
REQ-022 A stuff bit that became pending while stuff_en=1 is still inserted if stuff_en falls before the slot frees (trailing CRC stuff bit).
REQ-023 S_FIXED:
- Dynamic stuffing is off.
- One fixed stuff bit is inserted on entry, before the next data bit, then after every FIXED_INTERVAL data bits.
- Fixed stuff bits assert bit_is_stuff but do not increment stuff_count.
REQ-024 stuff_count behaviour:
- Cleared on the S_IDLE->S_DYN transition.
- +1 per dynamic stuff bit loaded; wraps 7->0.
- Held in all other states.
REQ-025 A tick with bit_valid=0 (underrun) is tolerated silently; no error is raised.
REQ-026 Mode changes apply to bits loaded from the next edge; the bit already in the output register is unaffected.

Reset
REQ-027 Reset values:
- bit_out=0, bit_valid=0, bit_is_stuff=0, stuff_count=0.
- run_cnt=0, last bit=1 (recessive), interval counter=0, state S_IDLE, no stuff pending.
- in_ready=1 after release.
REQ-028 Reset mid-frame discards the held bit and any pending stuff bit; no stuff bit is emitted after release.

Configuration
REQ-029 With CAN_STUFF_FD_FIXED_EN defined, S_FIXED and the fixed-stuff interval logic of REQ-023 are compiled in.
REQ-030 Without it, fixed_mode is kept as a port but ignored, S_FIXED is unreachable, and behaviour is classic CAN only.

Structure
REQ-031 Package can_pkg holds stuff_state_t (S_IDLE, S_DYN, S_FIXED), CAN_RUN_LEN_DEFAULT=5 and CAN_FD_FIXED_INTERVAL=4.
REQ-032 Sub-module can_run_counter: 4-bit counter with clear, increment and terminal-count compare. It is instantiated for run_cnt and, when the macro is defined, for the fixed interval.

Verification
REQ-033 stuff_en=1, tick every 4 cycles, input 1,1,1,1,1,1 -> bit_out 1,1,1,1,1,0(stuff),1; stuff_count=1.
REQ-034 stuff_en=1, input 0,0,0,0,0,1,1,1,1 -> 0x5, stuff 1, then 1,1,1,1, stuff 0 (the stuff bit opens the run); stuff_count=2.
REQ-035 stuff_en falls on the edge that loads the fifth 1 -> stuff 0 still emitted with in_ready=0 in that slot; later bits are unstuffed.
REQ-036 RUN_LEN=3, input 0,0,0,0 -> 0,0,0, stuff 1, 0.
REQ-037 Macro defined, fixed_mode=1, last bit 0, input 1,0,1,0,1,0,1,0 -> stuff 1, 1,0,1,0, stuff 1, 1,0,1,0, stuff 1; stuff_count unchanged.
REQ-038 Reset with a stuff bit pending -> all outputs 0 immediately; after release bit_valid=0 and no stuff bit is emitted.
